imem_port_arbiter: RTL

- Shares the single-port 2048x32 instruction BSRAM between two requesters:
  - the CPU instruction-fetch port (read-only);
  - the loader/debug port (read/write), used by the UART bootloader and the debugger.
- Drives the BSRAM control pins (ce, oce, wre, ad, din) and routes the 1-cycle synchronous read data back to the requester that issued the read.
- Loader has priority; a starvation counter bounds how long fetch can be blocked, except while the loader asserts its lock.

---
 rtl/imem_port_arbiter_if.sv | 55 +++++
 rtl/imem_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter_if
// Bundles the three buses around the instruction-BSRAM arbiter:
//   fetch port  : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//   loader port : ld_req/ld_we/ld_lock/ld_addr/ld_wdata in,
//                 ld_gnt/ld_rvalid/ld_rdata out
//   BSRAM pins  : mem_ce/mem_oce/mem_wre/mem_ad/mem_din out, mem_dout in
// Modport 'slave' is the arbiter's view; 'master' is the view of the
// requesters and memory surrounding it.
// -----------------------------------------------------------------------------
interface imem_port_arbiter_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 32
);
    // Fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    // Loader / debug port
    logic          ld_req;
    logic          ld_we;
    logic          ld_lock;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    // BSRAM pins
    logic          mem_ce;
    logic          mem_oce;
    logic          mem_wre;
    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  if_req, if_addr,
        input  ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        input  mem_dout,
        output if_gnt, if_rvalid, if_rdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_ce, mem_oce, mem_wre, mem_ad, mem_din
    );

    modport master (
        output if_req, if_addr,
        output ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        output mem_dout,
        input  if_gnt, if_rvalid, if_rdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_ce, mem_oce, mem_wre, mem_ad, mem_din
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
// Shares one single-port 2^AW x DW instruction BSRAM between the CPU fetch
// port (read-only) and the loader/debug port (read/write).
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - imem_port_arbiter_if.slave (fetch, loader and BSRAM pin groups)
// Arbitration is combinational in the request cycle; read data comes back
// from the BSRAM one cycle later and is tagged to its requester by a
// registered owner flag. The loader has priority, but a saturating starvation
// counter forces one fetch win after STARVE_MAX consecutive lost fetch
// requests, unless the loader holds ld_lock.
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int unsigned AW         = 11,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    imem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_e        owner_q, owner_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic [AW-1:0] ad_q, ad_d;
    logic [DW-1:0] din_q, din_d;
    logic          if_gnt_s;
    logic          ld_gnt_s;
    logic          any_gnt_s;

    // Winner selection: loader unless fetch has been starved long enough.
    always_comb begin
        if_gnt_s = 1'b0;
        ld_gnt_s = 1'b0;
        if (reset) begin
            if_gnt_s = 1'b0;
            ld_gnt_s = 1'b0;
        end else if (bus.ld_req &&
                     (!bus.if_req || bus.ld_lock || (starve_cnt_q < STARVE_LIM))) begin
            ld_gnt_s = 1'b1;
        end else if (bus.if_req && !bus.ld_lock) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            ld_gnt_s = 1'b0;
        end
    end

    assign any_gnt_s = if_gnt_s | ld_gnt_s;

    // Next state: owner of the in-flight read, starvation count, held pins.
    always_comb begin
        owner_d      = OWN_NONE;
        starve_cnt_d = 4'd0;
        ad_d         = ad_q;
        din_d        = din_q;
        if (reset) begin
            owner_d      = OWN_NONE;
            starve_cnt_d = 4'd0;
            ad_d         = '0;
            din_d        = '0;
        end else begin
            // Writes produce no response, so they leave the owner at none.
            if (if_gnt_s) begin
                owner_d = OWN_FETCH;
            end else if (ld_gnt_s && !bus.ld_we) begin
                owner_d = OWN_LOADER;
            end else begin
                owner_d = OWN_NONE;
            end

            // Only a pending, unlocked, refused fetch counts as starvation.
            if (bus.if_req && !bus.ld_lock && !if_gnt_s) begin
                if (starve_cnt_q >= STARVE_LIM) begin
                    starve_cnt_d = STARVE_LIM;
                end else begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end else begin
                starve_cnt_d = 4'd0;
            end

            // Address and write data only move on a grant so idle pins stay quiet.
            if (if_gnt_s) begin
                ad_d = bus.if_addr;
            end else if (ld_gnt_s) begin
                ad_d = bus.ld_addr;
            end else begin
                ad_d = ad_q;
            end

            if (any_gnt_s) begin
                din_d = bus.ld_wdata;
            end else begin
                din_d = din_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= 4'd0;
            ad_q         <= '0;
            din_q        <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            ad_q         <= ad_d;
            din_q        <= din_d;
        end
    end

    // BSRAM drive: ad/din come from next-state so a grant reaches the pins
    // in its own cycle while idle cycles present the held values.
    assign bus.mem_ce  = any_gnt_s;
    assign bus.mem_wre = ld_gnt_s & bus.ld_we;
    assign bus.mem_oce = ~reset;
    assign bus.mem_ad  = ad_d;
    assign bus.mem_din = din_d;

    assign bus.if_gnt  = if_gnt_s;
    assign bus.ld_gnt  = ld_gnt_s;

    // Responses: a read in flight across a reset edge is dropped.
    assign bus.if_rvalid = ~reset & (owner_q == OWN_FETCH);
    assign bus.ld_rvalid = ~reset & (owner_q == OWN_LOADER);
    assign bus.if_rdata  = bus.mem_dout;
    assign bus.ld_rdata  = bus.mem_dout;

endmodule
